// File: rtl/alu_branch_unit.sv
// Registered execute stage of the 8-bit CPU: add/sub datapath, move/branch decoder,
// sticky carry/borrow flags and a toggle output. Every output is a flop.
module alu_branch_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] op,
  input  logic [7:0] dIn0,
  input  logic [7:0] dIn1,
  input  logic [3:0] addrs,
  output logic [7:0] dOut,
  output logic       cOut,
  output logic       bOut,
  output logic       bcf,
  output logic       bbf,
  output logic       buc,
  output logic       toggleOut
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMov = 2'b10;
  localparam logic [1:0] OpNop = 2'b11;

  localparam logic [2:0] SubBcf = 3'h0;
  localparam logic [2:0] SubBbf = 3'h1;
  localparam logic [2:0] SubBuc = 3'h2;
  localparam logic [2:0] SubTgl = 3'h3;

  logic [7:0] dout_q, dout_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       bcf_q, bcf_d;
  logic       bbf_q, bbf_d;
  logic       buc_q, buc_d;
  logic       toggle_q, toggle_d;

  logic [8:0] sum;
  logic [7:0] diff;

  assign sum  = {1'b0, dIn0} + {1'b0, dIn1};
  assign diff = dIn0 - dIn1;

  // Pulses and the result default to zero so any cycle that does not re-assert them clears them.
  always_comb begin
    dout_d   = 8'h00;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    bcf_d    = 1'b0;
    bbf_d    = 1'b0;
    buc_d    = 1'b0;
    toggle_d = toggle_q;
    if (enable) begin
      unique case (op)
        OpAdd: begin
          {carry_d, dout_d} = sum;
        end
        OpSub: begin
          dout_d   = diff;
          borrow_d = (dIn0 < dIn1);
        end
        OpMov: begin
          if (!addrs[3]) begin
            dout_d = dIn0;
          end else if (!addrs[2]) begin
            // Branch conditions use the flags as they stood before this edge.
            case (addrs[2:0])
              SubBcf: begin
                bcf_d  = carry_q;
                dout_d = carry_q ? dIn0 : 8'h00;
              end
              SubBbf: begin
                bbf_d  = borrow_q;
                dout_d = borrow_q ? dIn0 : 8'h00;
              end
              SubBuc: begin
                buc_d  = 1'b1;
                dout_d = dIn0;
              end
              SubTgl: begin
                toggle_d = ~toggle_q;
              end
              default: ;
            endcase
          end
        end
        OpNop: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= 8'h00;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      bcf_q    <= 1'b0;
      bbf_q    <= 1'b0;
      buc_q    <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      bcf_q    <= bcf_d;
      bbf_q    <= bbf_d;
      buc_q    <= buc_d;
      toggle_q <= toggle_d;
    end
  end

  assign dOut      = dout_q;
  assign cOut      = carry_q;
  assign bOut      = borrow_q;
  assign bcf       = bcf_q;
  assign bbf       = bbf_q;
  assign buc       = buc_q;
  assign toggleOut = toggle_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Bench for alu_branch_unit: behavioural model checked every cycle, plus directed
// vectors with hand-computed literal expectations.
module tb_alu_branch_unit;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] op;
  logic [7:0] dIn0;
  logic [7:0] dIn1;
  logic [3:0] addrs;
  logic [7:0] dOut;
  logic       cOut;
  logic       bOut;
  logic       bcf;
  logic       bbf;
  logic       buc;
  logic       toggleOut;

  int n_cmp = 0;
  int n_bad = 0;
  logic run = 1'b0;

  alu_branch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .op        (op),
    .dIn0      (dIn0),
    .dIn1      (dIn1),
    .addrs     (addrs),
    .dOut      (dOut),
    .cOut      (cOut),
    .bOut      (bOut),
    .bcf       (bcf),
    .bbf       (bbf),
    .buc       (buc),
    .toggleOut (toggleOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dout;
    logic       c;
    logic       b;
    logic       bcf;
    logic       bbf;
    logic       buc;
    logic       tog;
  } st_t;

  st_t m;

  // Architectural model: next visible state from the current one and the sampled inputs.
  function automatic st_t step(st_t s, logic en, logic [1:0] o, logic [7:0] a,
                               logic [7:0] bb, logic [3:0] ad);
    st_t n;
    int  t;
    n      = s;
    n.dout = 8'h00;
    n.bcf  = 1'b0;
    n.bbf  = 1'b0;
    n.buc  = 1'b0;
    if (!en) return n;
    if (o == 2'd0) begin
      t      = int'(a) + int'(bb);
      n.dout = 8'(t % 256);
      n.c    = (t > 255);
    end else if (o == 2'd1) begin
      t      = int'(a) - int'(bb) + 256;
      n.dout = 8'(t % 256);
      n.b    = (int'(a) < int'(bb));
    end else if (o == 2'd2) begin
      if (int'(ad) < 8) n.dout = a;
      else if (ad == 4'd8) begin
        n.bcf  = s.c;
        n.dout = s.c ? a : 8'h00;
      end else if (ad == 4'd9) begin
        n.bbf  = s.b;
        n.dout = s.b ? a : 8'h00;
      end else if (ad == 4'd10) begin
        n.buc  = 1'b1;
        n.dout = a;
      end else if (ad == 4'd11) begin
        n.tog = ~s.tog;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step(m, enable, op, dIn0, dIn1, addrs);
  end

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (run) begin
      chk8("model dOut", dOut, m.dout);
      chk1("model cOut", cOut, m.c);
      chk1("model bOut", bOut, m.b);
      chk1("model bcf", bcf, m.bcf);
      chk1("model bbf", bbf, m.bbf);
      chk1("model buc", buc, m.buc);
      chk1("model toggleOut", toggleOut, m.tog);
    end
  end

  task automatic all_zero(string nm);
    chk8({nm, " dOut"}, dOut, 8'h00);
    chk1({nm, " cOut"}, cOut, 1'b0);
    chk1({nm, " bOut"}, bOut, 1'b0);
    chk1({nm, " bcf"}, bcf, 1'b0);
    chk1({nm, " bbf"}, bbf, 1'b0);
    chk1({nm, " buc"}, buc, 1'b0);
    chk1({nm, " toggleOut"}, toggleOut, 1'b0);
  endtask

  // Drive one op just after an edge, then return 1 time unit after the sampling edge.
  task automatic cyc(logic en, logic [1:0] o, logic [7:0] a, logic [7:0] bb, logic [3:0] ad);
    enable = en;
    op     = o;
    dIn0   = a;
    dIn1   = bb;
    addrs  = ad;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    op     = 2'b11;
    dIn0   = 8'h00;
    dIn1   = 8'h00;
    addrs  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    rst_n = 1'b1;
    run   = 1'b1;

    cyc(1'b1, 2'b00, 8'h03, 8'h01, 4'h0);
    chk8("add 3+1 dOut", dOut, 8'h04);
    chk1("add 3+1 cOut", cOut, 1'b0);
    cyc(1'b1, 2'b00, 8'hFF, 8'h01, 4'h0);
    chk8("add FF+1 dOut", dOut, 8'h00);
    chk1("add FF+1 cOut", cOut, 1'b1);
    cyc(1'b1, 2'b01, 8'h03, 8'h01, 4'h0);
    chk8("sub 3-1 dOut", dOut, 8'h02);
    chk1("sub 3-1 bOut", bOut, 1'b0);
    chk1("sub 3-1 cOut held", cOut, 1'b1);
    cyc(1'b1, 2'b01, 8'h01, 8'h03, 4'h0);
    chk8("sub 1-3 dOut", dOut, 8'hFE);
    chk1("sub 1-3 bOut", bOut, 1'b1);
    chk1("sub 1-3 cOut held", cOut, 1'b1);

    cyc(1'b1, 2'b10, 8'h03, 8'h00, 4'h8);
    chk1("bcf taken pulse", bcf, 1'b1);
    chk8("bcf taken dOut", dOut, 8'h03);
    cyc(1'b1, 2'b00, 8'h03, 8'h01, 4'h0);
    cyc(1'b1, 2'b10, 8'h03, 8'h00, 4'h8);
    chk1("bcf not taken", bcf, 1'b0);
    chk8("bcf not taken dOut", dOut, 8'h00);

    // Carry is now 0, borrow 1: addr 8 falls through, addr 9 branches.
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 16; a++) begin
        cyc(1'b1, 2'b10, 8'h03, 8'hAA, 4'(a));
        if (a < 8) chk8("sweep mov dOut", dOut, 8'h03);
        if (a == 9) chk1("sweep bbf", bbf, 1'b1);
        if (a == 10) chk1("sweep buc", buc, 1'b1);
        if (a == 11) chk1("sweep toggle", toggleOut, (pass == 0));
        if (a >= 12) chk8("sweep reserved dOut", dOut, 8'h00);
      end
    end

    cyc(1'b1, 2'b00, 8'hFF, 8'h01, 4'h0);
    cyc(1'b1, 2'b10, 8'h00, 8'h00, 4'hB);
    cyc(1'b0, 2'b00, 8'hFF, 8'hFF, 4'hA);
    chk8("idle dOut", dOut, 8'h00);
    chk1("idle cOut held", cOut, 1'b1);
    chk1("idle toggle held", toggleOut, 1'b1);
    chk1("idle buc", buc, 1'b0);
    cyc(1'b1, 2'b11, 8'h77, 8'h11, 4'hA);
    chk8("nop dOut", dOut, 8'h00);
    chk1("nop cOut held", cOut, 1'b1);

    cyc(1'b1, 2'b10, 8'h55, 8'h00, 4'hA);
    chk1("buc before reset", buc, 1'b1);
    chk8("buc dOut", dOut, 8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async reset");
    @(posedge clk);
    #1;
    all_zero("held reset");
    enable = 1'b1;
    op     = 2'b11;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("no pulse after release", buc, 1'b0);
    chk8("dOut after release", dOut, 8'h00);
    cyc(1'b1, 2'b00, 8'h80, 8'h90, 4'h0);
    chk8("add after reset dOut", dOut, 8'h10);
    chk1("add after reset cOut", cOut, 1'b1);
    @(negedge clk);
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
